// File: rtl/logicnets_layer_skid_stage.sv
// Registered valid/ready boundary between two LogicNets LUT layers.
// Two-entry skid buffer: full throughput with a registered s_ready.
module logicnets_layer_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  sample_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_fire, out_fire;

  assign s_ready      = rdy_q & ~flush;
  assign m_valid      = (state_q != EMPTY);
  assign m_data       = main_q;
  assign occupancy    = state_q;
  assign sample_count = cnt_q;
  assign in_fire      = s_valid & s_ready;
  assign out_fire     = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (in_fire && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = s_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = s_data;
          end else if (in_fire) begin
            skid_d  = s_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // ready is a pure function of the next state, so it can be registered
    rdy_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_logicnets_layer_skid_stage.sv
// Bench for logicnets_layer_skid_stage: directed cases plus random
// valid/ready traffic against a queue-based reference model.
module tb_logicnets_layer_skid_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        flush;
  logic [1:0]  occupancy;
  logic [15:0] sample_count;

  logic [31:0] s_data4;
  logic        s_valid4;
  logic        s_ready4;
  logic [31:0] m_data4;
  logic        m_valid4;
  logic        m_ready4;
  logic [1:0]  occ4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  int          cnt;
  bit          last_inf;
  logic [31:0] outs[$];

  always #5 clk = ~clk;

  logicnets_layer_skid_stage dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .flush(flush), .occupancy(occupancy),
    .sample_count(sample_count)
  );

  logicnets_layer_skid_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_data(s_data4), .s_valid(s_valid4), .s_ready(s_ready4),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready4),
    .flush(1'b0), .occupancy(occ4),
    .sample_count(cnt4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("mvalid", 64'(m_valid), 64'(q.size() > 0));
    if (q.size() > 0)
      chk("mdata", 64'(m_data), 64'(q[0]));
    chk("occ", 64'(occupancy), 64'(q.size()));
    chk("sready", 64'(s_ready), 64'(!flush && q.size() < 2));
    chk("cnt", 64'(sample_count), 64'(cnt));
  endtask

  task automatic step();
    bit inf, outf;
    inf  = !rst && s_valid && !flush && q.size() < 2;
    outf = q.size() > 0 && m_ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(s_data);
      if (inf && cnt < 65535) cnt++;
    end
    last_inf = inf;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int c0;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; flush = 1'b0;
    s_valid4 = 1'b0; s_data4 = '0; m_ready4 = 1'b1;
    q.delete(); cnt = 0;

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_mv", 64'(m_valid), 64'd0);
    chk("rst_md", 64'(m_data), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_cnt", 64'(sample_count), 64'd0);
    rst = 1'b0;
    step();
    chk("rst_srdy", 64'(s_ready), 64'd1);

    // stream
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 32'(i);
      step();
      chk("stream_md", 64'(m_data), 64'(i));
    end
    chk("cnt16", 64'(sample_count), 64'd16);
    s_valid = 1'b0;
    step(); step();

    // backpressure
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 32'hA5A5A5A5; step();
    s_data = 32'h5A5A5A5A; step();
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_srdy", 64'(s_ready), 64'd0);
    s_data = 32'hFFFFFFFF; step(); step();
    chk("bp_hold", 64'(occupancy), 64'd2);
    m_ready = 1'b1;
    outs.delete();
    for (int i = 0; i < 8; i++) begin
      if (m_valid && m_ready) outs.push_back(m_data);
      step();
      if (last_inf) s_valid = 1'b0;
    end
    chk("bp_n", 64'(outs.size()), 64'd3);
    if (outs.size() == 3) begin
      chk("bp_o0", 64'(outs[0]), 64'hA5A5A5A5);
      chk("bp_o1", 64'(outs[1]), 64'h5A5A5A5A);
      chk("bp_o2", 64'(outs[2]), 64'hFFFFFFFF);
    end

    // flush at occupancy 2
    m_ready = 1'b0; s_valid = 1'b1;
    s_data = 32'h11111111; step();
    s_data = 32'h22222222; step();
    chk("fl_pre", 64'(occupancy), 64'd2);
    c0 = cnt;
    flush = 1'b1; s_data = 32'h33333333;
    step();
    flush = 1'b0; s_valid = 1'b0;
    chk("fl_mv", 64'(m_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_cnt", 64'(sample_count), 64'(c0));
    step();

    // saturation on the 4-bit counter instance
    s_valid4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      s_data4 = 32'(i);
      step();
      chk("sat", 64'(cnt4), 64'(i > 15 ? 15 : i));
    end
    s_valid4 = 1'b0;

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      s_valid = ($urandom_range(0, 9) < 6);
      m_ready = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 511) == 0);
      s_data  = $urandom;
      step();
    end
    rst = 1'b0; flush = 1'b0; s_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
